// File: rtl/codec_pkg.sv
// -----------------------------------------------------------------------------
// codec_pkg
// Shared definitions for the one-hot code expander:
//   - CODE_W_DEFAULT : default code width (output width is 2**CODE_W)
//   - CNT_W          : width of the hold/gap down-counter
//   - state_e        : expander FSM states (IDLE, HOLD, GAP)
//   - onehot_of()    : decode of a code index into a one-hot word
//   - parity_of()    : XOR-reduction used for even-parity checking
// -----------------------------------------------------------------------------
package codec_pkg;

  localparam int CODE_W_DEFAULT = 3;
  localparam int CNT_W          = 8;
  localparam int MAX_N          = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Wide decode; callers size-cast the result down to their own output width.
  function automatic logic [MAX_N-1:0] onehot_of(input logic [7:0] idx);
    onehot_of = MAX_N'(1) << idx;
  endfunction

  // Even-parity helper: returns the bit that makes the whole word even.
  function automatic logic parity_of(input logic [31:0] v);
    parity_of = ^v;
  endfunction

endpackage

// File: rtl/onehot_code_expander_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Loadable 8-bit down-counter shared by the HOLD and GAP phases.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (count -> 0)
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one; saturates at zero
//   zero     - count is zero
// -----------------------------------------------------------------------------
module hold_counter
  import codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load wins over decrement, decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 8'd0);

endmodule

// File: rtl/onehot_code_expander.sv
// -----------------------------------------------------------------------------
// onehot_code_expander
// Accepts an encoded index over a valid/ready handshake and drives a
// registered one-hot line for HOLD_CYCLES cycles, pulses done, then keeps
// the block busy for GAP_CYCLES idle cycles before accepting again.
// abort cancels a hold or gap; abort also blocks acceptance while idle.
//
// Optional feature (macro CODE_PARITY_EN): adds code_par (even parity over
// {code, code_en}) and par_err; a code with bad parity is dropped and
// par_err pulses for one cycle.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   code_valid  - code word present
//   code_ready  - block can accept (IDLE, no abort, out of reset)
//   code        - encoded index
//   code_en     - 0: code consumed without producing output
//   code_par    - (CODE_PARITY_EN) even parity over {code, code_en}
//   abort       - cancel current hold/gap
//   onehot      - registered one-hot output
//   busy        - high in HOLD or GAP
//   done        - one-cycle pulse after a hold completes normally
//   par_err     - (CODE_PARITY_EN) one-cycle pulse on dropped bad-parity code
// -----------------------------------------------------------------------------
module onehot_code_expander
  import codec_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEFAULT,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   code_valid,
  output logic                   code_ready,
  input  logic [CODE_W-1:0]      code,
  input  logic                   code_en,
`ifdef CODE_PARITY_EN
  input  logic                   code_par,
  output logic                   par_err,
`endif
  input  logic                   abort,
  output logic [(2**CODE_W)-1:0] onehot,
  output logic                   busy,
  output logic                   done
);

  localparam int               N         = 2**CODE_W;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic             HAS_GAP   = (GAP_CYCLES > 0);

  state_e           state_r;
  logic             accept;
  logic             par_ok;
  logic             start_hold;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [N-1:0]     onehot_nx;

  // Ready is held low during reset even though the state register reads IDLE.
  assign code_ready = rst_n & (state_r == IDLE) & ~abort;
  assign accept     = code_valid & code_ready;

`ifdef CODE_PARITY_EN
  assign par_ok = (code_par == parity_of(32'({code, code_en})));
`else
  assign par_ok = 1'b1;
`endif

  assign start_hold = accept & code_en & par_ok;
  assign onehot_nx  = N'(onehot_of(8'(code)));

  // Counter control: load on entry to HOLD/GAP, count down while in them.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    cnt_dec  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_hold) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LOAD;
        end else begin
          cnt_load = 1'b0;
        end
      end
      HOLD: begin
        if (abort) begin
          cnt_dec = 1'b0;
        end else if (cnt_zero) begin
          if (HAS_GAP) begin
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
          end else begin
            cnt_load = 1'b0;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (!abort && !cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          cnt_dec = 1'b0;
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  hold_counter u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Expander FSM with registered onehot/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      onehot  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_hold) begin
            state_r <= HOLD;
            onehot  <= onehot_nx;
            busy    <= 1'b1;
          end else begin
            onehot  <= '0;
            busy    <= 1'b0;
          end
        end
        HOLD: begin
          if (abort) begin
            state_r <= IDLE;
            onehot  <= '0;
            busy    <= 1'b0;
          end else if (cnt_zero) begin
            onehot  <= '0;
            done    <= 1'b1;
            state_r <= HAS_GAP ? GAP : IDLE;
            busy    <= HAS_GAP;
          end else begin
            state_r <= HOLD;
          end
        end
        GAP: begin
          if (abort || cnt_zero) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= GAP;
          end
        end
        default: begin
          state_r <= IDLE;
          onehot  <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CODE_PARITY_EN
  // One-cycle flag for an accepted code whose parity does not check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= accept & ~par_ok;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_code_expander.sv
// -----------------------------------------------------------------------------
// tb_onehot_code_expander
// Directed bench: a vector table of single transactions, a back-to-back
// sweep, abort, zero-gap back-to-back (second instance), mid-hold reset and,
// with CODE_PARITY_EN, a bad-parity drop.
// -----------------------------------------------------------------------------
module tb_onehot_code_expander;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       code_valid, code_ready, code_en, abort;
  logic [2:0] code;
  logic [7:0] onehot;
  logic       busy, done;

  logic       v2, r2, abort2;
  logic [2:0] c2;
  logic [7:0] oh2;
  logic       busy2, done2;

`ifdef CODE_PARITY_EN
  logic code_par, par_err, c2_par, par_err2;
  assign c2_par = ^{c2, 1'b1};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  onehot_code_expander #(.CODE_W(3), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_ready(code_ready),
    .code(code), .code_en(code_en),
`ifdef CODE_PARITY_EN
    .code_par(code_par), .par_err(par_err),
`endif
    .abort(abort), .onehot(onehot), .busy(busy), .done(done)
  );

  onehot_code_expander #(.CODE_W(3), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .code_valid(v2), .code_ready(r2),
    .code(c2), .code_en(1'b1),
`ifdef CODE_PARITY_EN
    .code_par(c2_par), .par_err(par_err2),
`endif
    .abort(abort2), .onehot(oh2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [2:0] code;
    logic       en;
    logic [7:0] exp_oh;
  } vec_t;

  vec_t vecs [8];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic v, input logic [2:0] c, input logic en);
    code_valid = v;
    code       = c;
    code_en    = en;
`ifdef CODE_PARITY_EN
    code_par   = ^{c, en};
`endif
  endtask

  // Called at a negedge; returns right after the accepting posedge.
  task automatic do_accept(input logic [2:0] c, input logic en);
    set_inputs(1'b1, c, en);
    for (int k = 0; k < 20 && !code_ready; k++) @(negedge clk);
    chk1("ready_before_accept", code_ready, 1'b1);
    @(posedge clk);
  endtask

  // Checks cycles 1..6 after an accept edge; drives next inputs at cycle 1.
  task automatic check_hold(input logic [7:0] exp, input logic en,
                            input logic nv, input logic [2:0] nc, input string tag);
    logic [7:0] eo;
    logic       ed, er, eb;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (en) begin
        eo = (k <= 4) ? exp : 8'h00;
        ed = (k == 5);
        er = (k == 6);
        eb = (k <= 5);
      end else begin
        eo = 8'h00;
        ed = 1'b0;
        er = 1'b1;
        eb = 1'b0;
      end
      chk8({tag, " onehot"}, onehot, eo);
      chk1({tag, " done"}, done, ed);
      chk1({tag, " ready"}, code_ready, er);
      chk1({tag, " busy"}, busy, eb);
      if (k == 1) set_inputs(nv, nc, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd5, 1'b1, 8'h20};
    vecs[1] = '{3'd3, 1'b0, 8'h00};
    vecs[2] = '{3'd0, 1'b1, 8'h01};
    vecs[3] = '{3'd7, 1'b1, 8'h80};
    vecs[4] = '{3'd2, 1'b1, 8'h04};
    vecs[5] = '{3'd6, 1'b0, 8'h00};
    vecs[6] = '{3'd1, 1'b1, 8'h02};
    vecs[7] = '{3'd4, 1'b1, 8'h10};

    rst_n  = 1'b0;
    abort  = 1'b0;
    abort2 = 1'b0;
    v2     = 1'b0;
    c2     = 3'd0;
    set_inputs(1'b0, 3'd0, 1'b0);

    // Reset state
    @(negedge clk);
    chk8("reset onehot", onehot, 8'h00);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset ready", code_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post reset ready", code_ready, 1'b1);

    // Table of single transactions
    for (int i = 0; i < 8; i++) begin
      do_accept(vecs[i].code, vecs[i].en);
      check_hold(vecs[i].exp_oh, vecs[i].en, 1'b0, 3'd0, $sformatf("vec%0d", i));
    end

    // Back-to-back sweep with valid held high
    set_inputs(1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_accept(3'(i), 1'b1);
      check_hold(8'(1 << i), 1'b1, (i < 7), 3'(i + 1), $sformatf("sweep%0d", i));
    end
    set_inputs(1'b0, 3'd0, 1'b1);

    // Abort in the 2nd HOLD cycle, then abort blocking an IDLE accept
    do_accept(3'd7, 1'b1);
    @(negedge clk);
    set_inputs(1'b0, 3'd0, 1'b1);
    chk8("abort c1 onehot", onehot, 8'h80);
    @(negedge clk);
    chk8("abort c2 onehot", onehot, 8'h80);
    abort = 1'b1;
    @(negedge clk);
    chk8("abort c3 onehot", onehot, 8'h00);
    chk1("abort c3 done", done, 1'b0);
    chk1("abort c3 busy", busy, 1'b0);
    chk1("abort c3 ready", code_ready, 1'b0);
    set_inputs(1'b1, 3'd1, 1'b1);
    @(negedge clk);
    chk8("abort idle onehot", onehot, 8'h00);
    chk1("abort idle busy", busy, 1'b0);
    chk1("abort idle done", done, 1'b0);
    abort = 1'b0;
    set_inputs(1'b0, 3'd0, 1'b1);
    @(negedge clk);
    chk1("after abort ready", code_ready, 1'b1);
    chk1("after abort done", done, 1'b0);

    // Zero-gap, one-cycle hold: accept in the done cycle
    v2 = 1'b1;
    c2 = 3'd2;
    chk1("g0 ready0", r2, 1'b1);
    @(negedge clk);
    chk8("g0 c1 onehot", oh2, 8'h04);
    chk1("g0 c1 done", done2, 1'b0);
    chk1("g0 c1 ready", r2, 1'b0);
    c2 = 3'd6;
    @(negedge clk);
    chk8("g0 c2 onehot", oh2, 8'h00);
    chk1("g0 c2 done", done2, 1'b1);
    chk1("g0 c2 ready", r2, 1'b1);
    @(negedge clk);
    chk8("g0 c3 onehot", oh2, 8'h40);
    chk1("g0 c3 done", done2, 1'b0);
    v2 = 1'b0;
    @(negedge clk);
    chk8("g0 c4 onehot", oh2, 8'h00);
    chk1("g0 c4 done", done2, 1'b1);
    @(negedge clk);
    chk1("g0 c5 done", done2, 1'b0);
    chk1("g0 c5 busy", busy2, 1'b0);

    // Asynchronous reset in the middle of a hold
    do_accept(3'd4, 1'b1);
    @(negedge clk);
    set_inputs(1'b0, 3'd0, 1'b1);
    @(negedge clk);
    chk8("rst hold onehot", onehot, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk8("rst async onehot", onehot, 8'h00);
    chk1("rst async ready", code_ready, 1'b0);
    chk1("rst async busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("after rst done", done, 1'b0);
      chk8("after rst onehot", onehot, 8'h00);
    end
    chk1("after rst ready", code_ready, 1'b1);

`ifdef CODE_PARITY_EN
    // Bad parity on code=1 is dropped with a par_err pulse
    set_inputs(1'b1, 3'd1, 1'b1);
    code_par = ~code_par;
    chk1("par ready", code_ready, 1'b1);
    @(negedge clk);
    set_inputs(1'b0, 3'd0, 1'b1);
    chk1("par_err pulse", par_err, 1'b1);
    chk8("par onehot", onehot, 8'h00);
    chk1("par busy", busy, 1'b0);
    @(negedge clk);
    chk1("par_err clear", par_err, 1'b0);
    chk1("par ready after", code_ready, 1'b1);
    do_accept(3'd1, 1'b1);
    @(negedge clk);
    set_inputs(1'b0, 3'd0, 1'b1);
    chk8("good par onehot", onehot, 8'h02);
    chk1("good par no err", par_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
